// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler sharing one consumer between NUM_CHAN FIFOs: pop, capture, present.
// Define FIFO_ARB_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fifo_rd_arbiter #(
  parameter int NUM_CHAN   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 1,
  localparam int CHAN_WIDTH = $clog2(NUM_CHAN)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_CHAN-1:0]            chan_en,
  input  logic [NUM_CHAN-1:0]            fifo_empty,
  output logic [NUM_CHAN-1:0]            fifo_rd_en,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] fifo_dout,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CHAN_WIDTH-1:0]          out_chan,
  output logic                           busy
);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_HOLD} state_t;

  state_t                state;
  logic [CHAN_WIDTH-1:0] grant, last_grant, sel;
  logic [CNT_W-1:0]      burst_cnt;
  logic [NUM_CHAN-1:0]   elig;
  logic                  sel_vld, rotate;

  assign elig = chan_en & ~fifo_empty;
  assign busy = (state != S_IDLE);

`ifdef FIFO_ARB_STRICT_PRIO_EN
  always_comb begin : p_prio
    sel     = '0;
    sel_vld = 1'b0;
    rotate  = 1'b1;
    for (int i = NUM_CHAN - 1; i >= 0; i--)
      if (elig[i]) begin
        sel     = CHAN_WIDTH'(i);
        sel_vld = 1'b1;
      end
  end
`else
  // A zero burst count means no burst is in progress (e.g. right after reset),
  // so the first grant always comes from the rotating scan.
  always_comb begin : p_rr
    int idx;
    idx     = 0;
    sel     = '0;
    sel_vld = 1'b0;
    rotate  = 1'b1;
    if (burst_cnt != '0 && int'(burst_cnt) < BURST_LEN && elig[last_grant]) begin
      sel     = last_grant;
      sel_vld = 1'b1;
      rotate  = 1'b0;
    end else begin
      for (int k = NUM_CHAN; k >= 1; k--) begin
        idx = (int'(last_grant) + k) % NUM_CHAN;
        if (elig[idx]) begin
          sel     = CHAN_WIDTH'(idx);
          sel_vld = 1'b1;
        end
      end
    end
  end
`endif

  // Pop strobe is decided in the idle cycle itself; gating with reset_n keeps
  // it low the instant reset asserts.
  always_comb begin
    fifo_rd_en = '0;
    if (reset_n && state == S_IDLE && sel_vld) fifo_rd_en[sel] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      grant      <= '0;
      burst_cnt  <= '0;
      last_grant <= CHAN_WIDTH'(NUM_CHAN - 1);
    end else begin
      case (state)
        S_IDLE: if (sel_vld) begin
          grant <= sel;
          if (rotate) burst_cnt <= '0;
          state <= S_POP;
        end
        S_POP: begin
          out_data  <= fifo_dout[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
          out_chan  <= grant;
          out_valid <= 1'b1;
          burst_cnt <= burst_cnt + 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: if (out_ready) begin
          out_valid  <= 1'b0;
          last_grant <= grant;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: two instances (BURST_LEN 1 and 2) share stimulus;
// FIFO contents and expected grants come from a queue-based model.
module tb_fifo_rd_arbiter;
  localparam int NI = 2;
  localparam int NC = 2;
  localparam int DW = 32;
  localparam int CW = $clog2(NC);

  logic clk = 1'b0;
  logic reset_n;
  logic [NC-1:0] chan_en;
  logic out_ready;
  logic [NC-1:0]    empty     [NI];
  logic [NC*DW-1:0] dflat     [NI];
  logic [NC-1:0]    rd_en     [NI];
  logic             out_valid [NI];
  logic [DW-1:0]    out_data  [NI];
  logic [CW-1:0]    out_chan  [NI];
  logic             busy      [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fifo_rd_arbiter #(.NUM_CHAN(NC), .DATA_WIDTH(DW), .BURST_LEN(g + 1)) u_dut (
      .clock(clk), .reset_n(reset_n), .chan_en(chan_en), .fifo_empty(empty[g]),
      .fifo_rd_en(rd_en[g]), .fifo_dout(dflat[g]), .out_valid(out_valid[g]),
      .out_ready(out_ready), .out_data(out_data[g]), .out_chan(out_chan[g]), .busy(busy[g]));
  end

  logic [DW-1:0] fq   [NI][NC][$];
  logic [DW-1:0] dreg [NI][NC];
  int            pend [NI], age [NI], m_last [NI], m_run [NI], e_chan [NI];
  logic [DW-1:0] e_data [NI];
  int            seq_ch [NI][$], seq_cyc [NI][$];
  logic [DW-1:0] seq_dat [NI][$];
  int cycle = 0;
  int n_chk = 0;
  int n_fail = 0;

  // Channel the arbitration rules select, or -1 when nothing is eligible.
  function automatic int pick(logic [NC-1:0] el, int last, int run, int bl, output bit keep);
    keep = 1'b0;
`ifdef FIFO_ARB_STRICT_PRIO_EN
    for (int i = 0; i < NC; i++) if (el[i]) return i;
`else
    if (run > 0 && run < bl && el[last]) begin
      keep = 1'b1;
      return last;
    end
    for (int k = 1; k <= NC; k++) if (el[(last + k) % NC]) return (last + k) % NC;
`endif
    return -1;
  endfunction

  task automatic refresh();
    for (int g = 0; g < NI; g++)
      for (int c = 0; c < NC; c++) begin
        empty[g][c] = (fq[g][c].size() == 0);
        dflat[g][c*DW +: DW] = dreg[g][c];
      end
  endtask

  task automatic push(int c, logic [DW-1:0] v);
    for (int g = 0; g < NI; g++) fq[g][c].push_back(v);
    refresh();
  endtask

  task automatic clear_seq();
    for (int g = 0; g < NI; g++) begin
      seq_ch[g].delete(); seq_dat[g].delete(); seq_cyc[g].delete();
    end
  endtask

  // One clock: scoreboard at the falling edge, FIFO model pops just after the rising edge.
  task automatic cyc();
    logic [NC-1:0] popv [NI];
    logic [NC-1:0] el, ev;
    int e;
    bit keep;
    @(negedge clk);
    cycle++;
    for (int g = 0; g < NI; g++) begin
      popv[g] = rd_en[g];
      if (reset_n) begin
        el = chan_en & ~empty[g];
        if (pend[g] != 0) begin
          age[g]++;
          n_chk++;
          if (age[g] == 1) begin
            if (out_valid[g] !== 1'b0 || busy[g] !== 1'b1) begin
              n_fail++;
              $display("FAIL pop_cycle inst%0d cyc%0d: out_valid=%b busy=%b, required 0/1",
                       g, cycle, out_valid[g], busy[g]);
            end
          end else begin
            if (out_valid[g] !== 1'b1 || busy[g] !== 1'b1 || out_data[g] !== e_data[g] ||
                out_chan[g] !== CW'(e_chan[g])) begin
              n_fail++;
              $display("FAIL hold_word inst%0d cyc%0d: valid=%b data=%h chan=%0d, required 1 %h %0d",
                       g, cycle, out_valid[g], out_data[g], out_chan[g], e_data[g], e_chan[g]);
            end
            if (out_valid[g] === 1'b1 && out_ready === 1'b1) begin
              seq_ch[g].push_back(int'(out_chan[g]));
              seq_dat[g].push_back(out_data[g]);
              seq_cyc[g].push_back(cycle);
              pend[g] = 0;
            end
          end
          n_chk++;
          if (rd_en[g] !== '0) begin
            n_fail++;
            $display("FAIL pop_while_busy inst%0d cyc%0d: rd_en=%b, required 0", g, cycle, rd_en[g]);
          end
        end else begin
          e = pick(el, m_last[g], m_run[g], g + 1, keep);
          ev = '0;
          if (e >= 0) ev[e] = 1'b1;
          n_chk++;
          if (rd_en[g] !== ev || out_valid[g] !== 1'b0 || busy[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL grant inst%0d cyc%0d: rd_en=%b valid=%b busy=%b, required rd_en=%b 0 0",
                     g, cycle, rd_en[g], out_valid[g], busy[g], ev);
          end
          if (e >= 0) begin
            pend[g]   = 1;
            age[g]    = 0;
            e_chan[g] = e;
            e_data[g] = fq[g][e][0];
            m_run[g]  = keep ? m_run[g] + 1 : 1;
            m_last[g] = e;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++)
      for (int c = 0; c < NC; c++)
        if (popv[g][c] === 1'b1 && fq[g][c].size() > 0) dreg[g][c] = fq[g][c].pop_front();
    refresh();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    chan_en = '0;
    out_ready = 1'b0;
    for (int g = 0; g < NI; g++) begin
      for (int c = 0; c < NC; c++) fq[g][c].delete();
      pend[g] = 0; age[g] = 0; m_last[g] = NC - 1; m_run[g] = 0;
    end
    refresh();
    repeat (2) cyc();
    reset_n = 1'b1;
    clear_seq();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    chan_en = '1;
    push(0, 32'h1111_0000);
    push(1, 32'h2222_0000);
    cyc();
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (out_valid[g] !== 1'b0 || rd_en[g] !== '0 || busy[g] !== 1'b0 ||
          out_data[g] !== '0 || out_chan[g] !== '0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: valid=%b rd_en=%b busy=%b data=%h chan=%0d, required all 0",
                 g, out_valid[g], rd_en[g], busy[g], out_data[g], out_chan[g]);
      end
    end
  endtask

  task automatic test_reset_hold();
    int n;
    do_reset();
    chan_en = '1;
    push(0, $urandom);
    push(1, $urandom);
    push(1, $urandom);
    n = 0;
    while (!(out_valid[0] === 1'b1 && out_valid[1] === 1'b1) && n < 10) begin cyc(); n++; end
    n_chk++;
    if (n >= 10) begin n_fail++; $display("FAIL reset_hold_reach: timeout waiting for out_valid, required 1"); end
    #2 reset_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (out_valid[g] !== 1'b0 || rd_en[g] !== '0 || busy[g] !== 1'b0 || out_data[g] !== '0) begin
        n_fail++;
        $display("FAIL reset_hold inst%0d: valid=%b rd_en=%b busy=%b data=%h, required 0",
                 g, out_valid[g], rd_en[g], busy[g], out_data[g]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] w [NC][3];
    int exp [NI][6] = '{'{0, 1, 0, 1, 0, 1}, '{0, 0, 1, 1, 0, 1}};
    int k [NC];
    do_reset();
    chan_en = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < NC; c++) begin w[c][i] = $urandom; push(c, w[c][i]); end
    repeat (30) cyc();
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (seq_ch[g].size() != 6) begin
        n_fail++;
        $display("FAIL rr_count inst%0d: %0d words, required 6", g, seq_ch[g].size());
      end else begin
        k = '{0, 0};
        for (int i = 0; i < 6; i++) begin
          n_chk++;
          if (seq_ch[g][i] != exp[g][i] || seq_dat[g][i] !== w[exp[g][i]][k[exp[g][i]]]) begin
            n_fail++;
            $display("FAIL rr_order inst%0d word%0d: chan=%0d data=%h, required %0d %h",
                     g, i, seq_ch[g][i], seq_dat[g][i], exp[g][i], w[exp[g][i]][k[exp[g][i]]]);
          end
          k[exp[g][i]]++;
          if (g == 0 && i > 0) begin
            n_chk++;
            if (seq_cyc[0][i] - seq_cyc[0][i-1] != 3) begin
              n_fail++;
              $display("FAIL rr_rate word%0d: spacing %0d cycles, required 3", i, seq_cyc[0][i] - seq_cyc[0][i-1]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_burst();
    int exp [NI][8] = '{'{0, 1, 0, 1, 0, 1, 0, 1}, '{0, 0, 1, 1, 0, 0, 1, 1}};
    do_reset();
    chan_en = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) for (int c = 0; c < NC; c++) push(c, $urandom);
    repeat (40) cyc();
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (seq_ch[g].size() != 8) begin
        n_fail++;
        $display("FAIL burst_count inst%0d: %0d words, required 8", g, seq_ch[g].size());
      end else
        for (int i = 0; i < 8; i++) begin
          n_chk++;
          if (seq_ch[g][i] != exp[g][i]) begin
            n_fail++;
            $display("FAIL burst_order inst%0d word%0d: chan=%0d, required %0d", g, i, seq_ch[g][i], exp[g][i]);
          end
        end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held [NI];
    int n;
    do_reset();
    chan_en = 2'b01;
    push(0, $urandom);
    push(0, $urandom);
    n = 0;
    while (out_valid[0] !== 1'b1 && n < 10) begin cyc(); n++; end
    n_chk++;
    if (n >= 10) begin n_fail++; $display("FAIL bp_reach: timeout waiting for out_valid, required 1"); end
    for (int g = 0; g < NI; g++) held[g] = out_data[g];
    repeat (10) begin
      cyc();
      for (int g = 0; g < NI; g++) begin
        n_chk++;
        if (out_valid[g] !== 1'b1 || out_data[g] !== held[g] || rd_en[g] !== '0) begin
          n_fail++;
          $display("FAIL bp_stall inst%0d: valid=%b data=%h rd_en=%b, required 1 %h 0",
                   g, out_valid[g], out_data[g], rd_en[g], held[g]);
        end
      end
    end
    out_ready = 1'b1;
    cyc();
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (out_valid[g] !== 1'b0 || rd_en[g] !== 2'b01) begin
        n_fail++;
        $display("FAIL bp_release inst%0d: valid=%b rd_en=%b, required 0 01", g, out_valid[g], rd_en[g]);
      end
    end
    repeat (4) cyc();
  endtask

  task automatic test_chan_mask();
    do_reset();
    chan_en = 2'b10;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) for (int c = 0; c < NC; c++) push(c, $urandom);
    repeat (20) cyc();
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (fq[g][0].size() != 3 || seq_ch[g].size() != 3 || seq_ch[g].sum() != 3) begin
        n_fail++;
        $display("FAIL chan_mask inst%0d: ch0 left=%0d words=%0d ch1 words=%0d, required 3 3 3",
                 g, fq[g][0].size(), seq_ch[g].size(), seq_ch[g].sum());
      end
    end
  endtask

  task automatic test_starve();
    int ones;
    do_reset();
    chan_en = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(1, $urandom);
    repeat (40) begin
      for (int g = 0; g < NI; g++) if (fq[g][0].size() < 2) fq[g][0].push_back($urandom);
      refresh();
      cyc();
    end
    ones = 0;
    n_chk++;
    if (seq_ch[0].size() < 8) begin
      n_fail++;
      $display("FAIL starve_count: %0d words, required at least 8", seq_ch[0].size());
    end else begin
      for (int i = 0; i < 8; i++) ones += seq_ch[0][i];
      n_chk++;
`ifdef FIFO_ARB_STRICT_PRIO_EN
      if (ones != 0) begin
        n_fail++;
        $display("FAIL strict_prio: ch1 grants in first 8 = %0d, required 0", ones);
      end
`else
      if (ones != 4 || seq_ch[0][0] != 0 || seq_ch[0][1] != 1) begin
        n_fail++;
        $display("FAIL rr_fair: ch1 grants in first 8 = %0d, required 4 alternating", ones);
      end
`endif
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (800) begin
      chan_en = NC'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push($urandom_range(0, NC - 1), $urandom);
      cyc();
    end
    for (int g = 0; g < NI; g++) begin
      n_chk++;
      if (seq_ch[g].size() < 20) begin
        n_fail++;
        $display("FAIL random_progress inst%0d: %0d words, required at least 20", g, seq_ch[g].size());
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    chan_en = '0;
    out_ready = 1'b0;
    for (int g = 0; g < NI; g++) begin
      for (int c = 0; c < NC; c++) dreg[g][c] = '0;
      pend[g] = 0; age[g] = 0; m_last[g] = NC - 1; m_run[g] = 0;
    end
    refresh();
    test_reset();
    test_reset_hold();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_chan_mask();
    test_starve();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
